register_file_mp: RTL

Parametrised multi-port register file for the pipelined RISC-V core: configurable read and write port counts, registered reads, and a per-register busy scoreboard for hazard detection. It sits in the decode stage. Read ports feed the ID/EX register, write ports come from writeback, and the reserve port comes from issue. An optional same-edge write-to-read bypass removes the one-cycle writeback hazard, and a tap port exports one architectural register for debug and display.

---
 rtl/register_file_mp.sv | 105 ++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file with registered reads, busy scoreboard and a debug tap.
// Optional same-edge write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file_mp #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_PORTS    = 2,
    parameter int unsigned WRITE_PORTS   = 1,
    parameter int unsigned TAP_ADDR      = 10
) (
    input  logic                                iClk,
    input  logic                                iRst_n,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] iReadAddress,
    output logic [READ_PORTS*DATA_WIDTH-1:0]    oRegData,
    output logic [READ_PORTS-1:0]               oBusy,
    input  logic [WRITE_PORTS-1:0]              iWriteEn,
    input  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] iWriteAddress,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0]   iDataIn,
    input  logic                                iReserveEn,
    input  logic [ADDRESS_WIDTH-1:0]            iReserveAddress,
    output logic [DATA_WIDTH-1:0]               oRegTap
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] TAP = ADDRESS_WIDTH'(TAP_ADDR);

    logic [DATA_WIDTH-1:0]            mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]            mem_d [DEPTH];
    logic [DEPTH-1:0]                 busy_q, busy_d;
    logic [READ_PORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [READ_PORTS-1:0]            rbusy_q, rbusy_d;
    logic [DATA_WIDTH-1:0]            tap_q, tap_d;

    // Ascending port order lets the highest write port win; the reserve comes last so it beats a clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int unsigned q = 0; q < WRITE_PORTS; q++) begin
            if (iWriteEn[q] && (iWriteAddress[q*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
                mem_d[iWriteAddress[q*ADDRESS_WIDTH +: ADDRESS_WIDTH]]  = iDataIn[q*DATA_WIDTH +: DATA_WIDTH];
                busy_d[iWriteAddress[q*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b0;
            end
        end
        if (iReserveEn && (iReserveAddress != '0)) begin
            busy_d[iReserveAddress] = 1'b1;
        end
    end

    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]    rd_val;
    logic                     rd_bsy;

    always_comb begin
        rdata_d = '0;
        rbusy_d = '0;
        tap_d   = '0;
        rd_addr = '0;
        rd_val  = '0;
        rd_bsy  = 1'b0;
        // Iteration READ_PORTS services the tap with the same lookup as the read ports.
        for (int unsigned p = 0; p <= READ_PORTS; p++) begin
            rd_addr = (p == READ_PORTS) ? TAP : iReadAddress[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            rd_val  = mem_q[rd_addr];
            rd_bsy  = busy_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned q = 0; q < WRITE_PORTS; q++) begin
                if (iWriteEn[q] && (iWriteAddress[q*ADDRESS_WIDTH +: ADDRESS_WIDTH] == rd_addr)) begin
                    rd_val = iDataIn[q*DATA_WIDTH +: DATA_WIDTH];
                    rd_bsy = 1'b0;
                end
            end
`endif
            if (rd_addr == '0) begin
                rd_val = '0;
                rd_bsy = 1'b0;
            end
            if (p == READ_PORTS) begin
                tap_d = rd_val;
            end else begin
                rdata_d[p*DATA_WIDTH +: DATA_WIDTH] = rd_val;
                rbusy_d[p]                          = rd_bsy;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            mem_q   <= '{default: '0};
            busy_q  <= '0;
            rdata_q <= '0;
            rbusy_q <= '0;
            tap_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
            tap_q   <= tap_d;
        end
    end

    assign oRegData = rdata_q;
    assign oBusy    = rbusy_q;
    assign oRegTap  = tap_q;

endmodule
